// File: rtl/fma16_pkg.sv
// Shared definitions for the fma16 vector runner: ROM vector field positions,
// ctrl and flag bit positions, and the sequencer state encoding.
package fma16_pkg;
   localparam int VEC_W      = 76;
   localparam int OP_W       = 16;
   localparam int FLG_W      = 4;
   localparam int CTRL_USE_W = 6;

   localparam int X_LSB    = 60;
   localparam int Y_LSB    = 44;
   localparam int Z_LSB    = 28;
   localparam int CTRL_LSB = 20;
   localparam int REXP_LSB = 4;
   localparam int FEXP_LSB = 0;

   localparam int CTRL_NEGZ   = 0;
   localparam int CTRL_NEGP   = 1;
   localparam int CTRL_ADD    = 2;
   localparam int CTRL_MUL    = 3;
   localparam int CTRL_RM_LSB = 4;

   localparam int FLG_NX = 0;
   localparam int FLG_UF = 1;
   localparam int FLG_OF = 2;
   localparam int FLG_NV = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SETTLE,
      ST_DONE
   } state_t;
endpackage

// File: rtl/fma16_vector_runner_if.sv
// Signal bundle between the vector runner and its environment (control, vector ROM, fma16).
// master = runner side, slave = environment side.
interface fma16_vector_runner_if #(parameter int ADDR_W = 17);
   logic                           start;
   logic [ADDR_W:0]                num_vectors;
   logic                           vec_rd_en;
   logic [ADDR_W-1:0]              vec_addr;
   logic [fma16_pkg::VEC_W-1:0]    vec_data;
   logic [15:0]                    x;
   logic [15:0]                    y;
   logic [15:0]                    z;
   logic                           mul;
   logic                           add;
   logic                           negp;
   logic                           negz;
   logic [1:0]                     roundmode;
   logic [15:0]                    result;
   logic [3:0]                     flags;
   logic                           busy;
   logic                           done;
   logic [ADDR_W:0]                vectors_run;
   logic [15:0]                    error_count;
   logic                           err_valid;
   logic [ADDR_W-1:0]              first_err_idx;
   logic [15:0]                    first_err_result;
   logic [3:0]                     first_err_flags;

   modport master (
      input  start, num_vectors, vec_data, result, flags,
      output vec_rd_en, vec_addr, x, y, z, mul, add, negp, negz, roundmode,
             busy, done, vectors_run, error_count, err_valid,
             first_err_idx, first_err_result, first_err_flags
   );

   modport slave (
      output start, num_vectors, vec_data, result, flags,
      input  vec_rd_en, vec_addr, x, y, z, mul, add, negp, negz, roundmode,
             busy, done, vectors_run, error_count, err_valid,
             first_err_idx, first_err_result, first_err_flags
   );
endinterface

// File: rtl/fma16_result_check.sv
// Combinational comparison of an fma16 result/flags pair against the expected values.
// Flags only participate when check_flags_i is set.
module fma16_result_check
   import fma16_pkg::*;
(
   input  logic [OP_W-1:0]  result_i,
   input  logic [FLG_W-1:0] flags_i,
   input  logic [OP_W-1:0]  rexp_i,
   input  logic [FLG_W-1:0] fexp_i,
   input  logic             check_flags_i,
   output logic             mismatch_o
);
   assign mismatch_o = (result_i != rexp_i) | (check_flags_i & (flags_i != fexp_i));
endmodule

// File: rtl/fma16_vector_runner.sv
// Replays ROM vectors into fma16 and scores each result; 3+DUT_LAT cycles per vector.
// No backpressure: ROM data is taken one cycle after the read strobe, starts while busy are dropped.
module fma16_vector_runner
   import fma16_pkg::*;
#(
   parameter int ADDR_W      = 17,
   parameter int DUT_LAT     = 0,
   parameter int CHECK_FLAGS = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   fma16_vector_runner_if.master bus
);
   localparam int CNT_W = (DUT_LAT < 1) ? 1 : $clog2(DUT_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(DUT_LAT);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic [ADDR_W:0]       num_q, num_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [OP_W-1:0]       x_q, x_d, y_q, y_d, z_q, z_d;
   logic [CTRL_USE_W-1:0] ctrl_q, ctrl_d;
   logic [OP_W-1:0]       rexp_q, rexp_d;
   logic [FLG_W-1:0]      fexp_q, fexp_d;
   logic [ADDR_W:0]       run_q, run_d;
   logic [15:0]           err_q, err_d;
   logic                  errv_q, errv_d;
   logic [ADDR_W-1:0]     ferr_idx_q, ferr_idx_d;
   logic [OP_W-1:0]       ferr_res_q, ferr_res_d;
   logic [FLG_W-1:0]      ferr_flg_q, ferr_flg_d;
   logic [ADDR_W:0]       idx_nxt;
   logic                  mismatch;
   logic                  unused_ctrl_hi;

   // ctrl[7:6] are reserved in the vector format
   assign unused_ctrl_hi = ^bus.vec_data[CTRL_LSB+6 +: 2];

   // Widened so the last-vector test also works for a full 2^ADDR_W suite
   assign idx_nxt = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

   fma16_result_check u_check (
      .result_i      (bus.result),
      .flags_i       (bus.flags),
      .rexp_i        (rexp_q),
      .fexp_i        (fexp_q),
      .check_flags_i (CHECK_FLAGS != 0),
      .mismatch_o    (mismatch)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      num_d      = num_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      ctrl_d     = ctrl_q;
      rexp_d     = rexp_q;
      fexp_d     = fexp_q;
      run_d      = run_q;
      err_d      = err_q;
      errv_d     = errv_q;
      ferr_idx_d = ferr_idx_q;
      ferr_res_d = ferr_res_q;
      ferr_flg_d = ferr_flg_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               run_d      = '0;
               err_d      = '0;
               errv_d     = 1'b0;
               ferr_idx_d = '0;
               ferr_res_d = '0;
               ferr_flg_d = '0;
               idx_d      = '0;
               num_d      = bus.num_vectors;
               state_d    = (bus.num_vectors == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            x_d     = bus.vec_data[X_LSB +: OP_W];
            y_d     = bus.vec_data[Y_LSB +: OP_W];
            z_d     = bus.vec_data[Z_LSB +: OP_W];
            ctrl_d  = bus.vec_data[CTRL_LSB +: CTRL_USE_W];
            rexp_d  = bus.vec_data[REXP_LSB +: OP_W];
            fexp_d  = bus.vec_data[FEXP_LSB +: FLG_W];
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q != LAT_C) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               if (mismatch) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (!errv_q) begin
                     errv_d     = 1'b1;
                     ferr_idx_d = idx_q;
                     ferr_res_d = bus.result;
                     ferr_flg_d = bus.flags;
                  end
               end
               run_d   = run_q + 1'b1;
               idx_d   = idx_q + 1'b1;
               state_d = (idx_nxt == num_q) ? ST_DONE : ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         num_q      <= '0;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         ctrl_q     <= '0;
         rexp_q     <= '0;
         fexp_q     <= '0;
         run_q      <= '0;
         err_q      <= '0;
         errv_q     <= 1'b0;
         ferr_idx_q <= '0;
         ferr_res_q <= '0;
         ferr_flg_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         num_q      <= num_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         ctrl_q     <= ctrl_d;
         rexp_q     <= rexp_d;
         fexp_q     <= fexp_d;
         run_q      <= run_d;
         err_q      <= err_d;
         errv_q     <= errv_d;
         ferr_idx_q <= ferr_idx_d;
         ferr_res_q <= ferr_res_d;
         ferr_flg_q <= ferr_flg_d;
      end
   end

   assign bus.vec_rd_en        = (state_q == ST_FETCH);
   assign bus.vec_addr         = idx_q;
   assign bus.x                = x_q;
   assign bus.y                = y_q;
   assign bus.z                = z_q;
   assign bus.mul              = ctrl_q[CTRL_MUL];
   assign bus.add              = ctrl_q[CTRL_ADD];
   assign bus.negp             = ctrl_q[CTRL_NEGP];
   assign bus.negz             = ctrl_q[CTRL_NEGZ];
   assign bus.roundmode        = ctrl_q[CTRL_RM_LSB +: 2];
   assign bus.busy             = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_SETTLE);
   assign bus.done             = (state_q == ST_DONE);
   assign bus.vectors_run      = run_q;
   assign bus.error_count      = err_q;
   assign bus.err_valid        = errv_q;
   assign bus.first_err_idx    = ferr_idx_q;
   assign bus.first_err_result = ferr_res_q;
   assign bus.first_err_flags  = ferr_flg_q;
endmodule

// File: doc/fma16_vector_runner.md
Name: fma16_vector_runner

Overview:
- Self-contained hardware sequencer that replays fma16 test vectors from a vector ROM into the fma16 datapath and checks each result.
- Sits directly upstream of fma16, driving its operand and control inputs, and consumes its result and flags.
- Lets the vector suites run on FPGA or emulation without a behavioural bench.
- Reports pass count, error count and a snapshot of the first failing vector.

Parameters:
- ADDR_W, 17: vector ROM address width; the maximum suite size is 2^ADDR_W vectors.
- DUT_LAT, 0: cycles of fma16 latency after operands are applied (0 means combinational).
- CHECK_FLAGS, 0: when 1, a flags mismatch also counts as an error.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: single-cycle pulse that begins a run.
- num_vectors, in, ADDR_W+1: number of vectors to run. Sampled on start.
- vec_rd_en, out, 1: ROM read strobe.
- vec_addr, out, ADDR_W: ROM read address.
- vec_data, in, 76: ROM data, valid exactly 1 cycle after vec_rd_en. Layout is {x[75:60], y[59:44], z[43:28], ctrl[27:20], rexp[19:4], fexp[3:0]}.
- x, out, 16: fma16 operand.
- y, out, 16: fma16 operand.
- z, out, 16: fma16 operand.
- mul, out, 1: fma16 control, from ctrl[3].
- add, out, 1: fma16 control, from ctrl[2].
- negp, out, 1: fma16 control, from ctrl[1].
- negz, out, 1: fma16 control, from ctrl[0].
- roundmode, out, 2: fma16 control, from ctrl[5:4].
- result, in, 16: fma16 result.
- flags, in, 4: fma16 flags {invalid, overflow, underflow, inexact}.
- busy, out, 1: high while a run is in progress.
- done, out, 1: high after a run completes, held until the next accepted start.
- vectors_run, out, ADDR_W+1: number of vectors checked in the current or last run.
- error_count, out, 16: mismatches; saturates at 16'hFFFF.
- err_valid, out, 1: first-error snapshot is valid.
- first_err_idx, out, ADDR_W: index of the first failing vector.
- first_err_result, out, 16: result observed at the first failure.
- first_err_flags, out, 4: flags observed at the first failure.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0: operands, controls, counters, snapshot, vec_rd_en, busy, done.
- FSM states: IDLE, FETCH, LOAD, SETTLE, DONE.
- IDLE or DONE, start=1:
  - Clear vectors_run, error_count, err_valid and the snapshot; clear done; idx=0; busy=1.
  - If num_vectors==0, go to DONE next cycle (done=1, counts 0). Otherwise go to FETCH.
- start while busy: ignored.
- FETCH: vec_rd_en=1, vec_addr=idx; next state LOAD.
- LOAD:
  - vec_data is valid. Register x, y, z, the controls, rexp and fexp. Only ctrl[5:0] is used; ctrl[7:6] is ignored.
  - Clear the settle counter; next state SETTLE.
  - Operands are visible to fma16 from the first SETTLE cycle.
- SETTLE:
  - While cnt<DUT_LAT: cnt++.
  - When cnt==DUT_LAT:
    - Mismatch = (result!=rexp) | (CHECK_FLAGS & (flags!=fexp)).
    - On mismatch: error_count++ (saturating). If err_valid==0, capture idx, result and flags, and set err_valid=1.
    - vectors_run++ and idx++.
    - If idx+1==num_vectors go to DONE, else go to FETCH.
- Throughput: 3+DUT_LAT cycles per vector.
- Operands stay stable from LOAD through the compare cycle and keep their last values in DONE and IDLE.
- DONE: busy=0, done=1; counters and snapshot are held.
- Entering DONE: done rises the cycle after the last compare.
- num_vectors=2^ADDR_W: the address wraps only after the final vector, so no re-fetch of index 0.
- reset_n asserted mid-run: immediate return to IDLE with everything cleared. A partial run leaves no residue.

Decomposition:
- Package fma16_pkg:
  - VEC_W=76 and the field bit-position localparams for the vector layout.
  - ctrl bit positions.
  - Flag index constants: FLG_NV, FLG_OF, FLG_UF, FLG_NX.
  - state_t enum.
- One sub-module, fma16_result_check: combinational. Inputs are result, flags, rexp, fexp and CHECK_FLAGS; output is mismatch. It is reusable by the software bench scoreboard.

Test Plan:
- Single vector, DUT_LAT=0, fma16 attached. Vector 3c00_3c00_0000_08_3c00_0 (1.0*1.0, mul=1, rz), num_vectors=1, start.
  - Required: vec_rd_en in cycle 1 after start, compare in cycle 3, done in cycle 4.
  - Final: vectors_run=1, error_count=0, err_valid=0.
- Injected failure. ROM has 3 vectors and the middle one has rexp corrupted to 3c01.
  - Required: error_count=1, err_valid=1, first_err_idx=1, first_err_result=3c00, vectors_run=3.
- Flags gating. One vector whose fexp differs from the DUT flags; run with CHECK_FLAGS=0, then with CHECK_FLAGS=1.
  - Required: error_count=0 with CHECK_FLAGS=0, error_count=1 with CHECK_FLAGS=1.
- Latency. DUT_LAT=2 with a 2-stage registered fma16 wrapper, 4 vectors.
  - Required: 5 cycles per vector, done at cycle 21, zero errors.
- Start edge cases:
  - num_vectors=0: done=1 one cycle after start, all counts 0.
  - A second start pulsed while busy: no restart, the run count is unchanged.
- Reset mid-run. Drop reset_n during SETTLE of vector 2.
  - Required: all outputs 0 at once.
  - A subsequent start runs from idx 0 with clean counters.
